// File: rtl/vend_txn.sv
// ---------------------------------------------------------------------------
// vend_txn - vending machine transaction controller
//
// Accumulates coin credit, checks purchase requests against a per-channel
// price table (cost = unit price * quantity, compared at full 2*DW width),
// issues a one-cycle dispense pulse and then pays out change in chunks of
// at most COIN_MAX over a valid/ready handshake.
//
// Handshake (change dispenser): change_valid/change_value are offered by this
// block and held stable until the cycle in which change_ready is high while
// change_valid is high; that edge is the transfer. change_ready is ignored
// while change_valid is low.
//
// States: IDLE (credit 0), COLLECT (credit > 0), VEND (dispense pulse cycle),
// CHANGE (paying out). All outputs are registered.
//
// Optional feature: define VEND_CANCEL_EN to add the cancel input and the
// refund path (cancel in COLLECT moves credit into change payout).
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   coin_valid, coin_value   coin inserted this cycle and its amount
//   sel_valid, sel_idx,      purchase request: channel and quantity
//   sel_count
//   price_table              unit price of channel i at [i*DW +: DW]
//   cancel                   refund request (VEND_CANCEL_EN only)
//   change_ready             change dispenser accepts the offered chunk
//   credit                   current credit
//   busy                     state is VEND or CHANGE
//   vend_valid, vend_idx,    one-cycle dispense pulse with channel/quantity
//   vend_count
//   change_valid,            change chunk offered and its amount
//   change_value
//   short_pulse              one-cycle pulse: purchase refused
//   coin_reject              one-cycle pulse: coin refused
// ---------------------------------------------------------------------------
module vend_txn #(
  parameter int DW       = 8,
  parameter int NPROD    = 4,
  parameter int COIN_MAX = 50,
  localparam int IW      = $clog2(NPROD)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [DW-1:0]       coin_value,
  input  logic                sel_valid,
  input  logic [IW-1:0]       sel_idx,
  input  logic [DW-1:0]       sel_count,
  input  logic [NPROD*DW-1:0] price_table,
`ifdef VEND_CANCEL_EN
  input  logic                cancel,
`endif
  input  logic                change_ready,
  output logic [DW-1:0]       credit,
  output logic                busy,
  output logic                vend_valid,
  output logic [IW-1:0]       vend_idx,
  output logic [DW-1:0]       vend_count,
  output logic                change_valid,
  output logic [DW-1:0]       change_value,
  output logic                short_pulse,
  output logic                coin_reject
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_CHANGE  = 2'd3
  } state_t;

  localparam logic [DW-1:0] COIN_CAP = DW'(COIN_MAX);

  state_t          state, state_d;
  logic [DW-1:0]   remaining, remaining_d;
  logic [DW-1:0]   credit_d, vend_count_d, change_value_d;
  logic [IW-1:0]   vend_idx_d;
  logic            busy_d, vend_valid_d, change_valid_d, short_d, reject_d;

  logic [DW-1:0]   price_sel;
  logic            idx_ok;
  logic [DW:0]     coin_sum;
  logic [DW-1:0]   eff;
  logic [2*DW-1:0] cost;
  logic            afford;
  logic [DW-1:0]   rem_after;

  function automatic logic [DW-1:0] chunk(input logic [DW-1:0] amt);
    return (amt > COIN_CAP) ? COIN_CAP : amt;
  endfunction

  // Price lookup; idx_ok stays low for a channel number with no table entry.
  always_comb begin
    price_sel = '0;
    idx_ok    = 1'b0;
    for (int i = 0; i < NPROD; i++) begin
      if (int'(sel_idx) == i) begin
        price_sel = price_table[i*DW +: DW];
        idx_ok    = 1'b1;
      end
    end
  end

  // Effective credit counts a same-cycle coin first, saturating at all-ones.
  assign coin_sum  = {1'b0, credit} + {1'b0, coin_value};
  assign eff       = coin_valid ? (coin_sum[DW] ? '1 : coin_sum[DW-1:0]) : credit;
  assign cost      = {{DW{1'b0}}, price_sel} * {{DW{1'b0}}, sel_count};
  assign afford    = idx_ok && (sel_count != '0) && ({{DW{1'b0}}, eff} >= cost);
  assign rem_after = remaining - change_value;

  always_comb begin
    state_d        = state;
    credit_d       = credit;
    remaining_d    = remaining;
    vend_valid_d   = 1'b0;
    vend_idx_d     = vend_idx;
    vend_count_d   = vend_count;
    change_valid_d = 1'b0;
    change_value_d = '0;
    short_d        = 1'b0;
    reject_d       = 1'b0;
    case (state)
      S_IDLE, S_COLLECT: begin
`ifdef VEND_CANCEL_EN
        if (cancel) begin
          // Refund wins over coins and selections; a coin this cycle bounces.
          reject_d = coin_valid;
          if (credit != '0) begin
            remaining_d    = credit;
            credit_d       = '0;
            state_d        = S_CHANGE;
            change_valid_d = 1'b1;
            change_value_d = chunk(credit);
          end
        end else
`endif
        if (sel_valid && afford) begin
          // cost <= eff here, so the low DW bits hold the whole cost.
          remaining_d  = eff - cost[DW-1:0];
          credit_d     = '0;
          state_d      = S_VEND;
          vend_valid_d = 1'b1;
          vend_idx_d   = sel_idx;
          vend_count_d = sel_count;
        end else begin
          short_d  = sel_valid;
          credit_d = eff;
          state_d  = (eff == '0) ? S_IDLE : S_COLLECT;
        end
      end
      S_VEND: begin
        reject_d = coin_valid;
        if (remaining != '0) begin
          state_d        = S_CHANGE;
          change_valid_d = 1'b1;
          change_value_d = chunk(remaining);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHANGE: begin
        reject_d       = coin_valid;
        change_valid_d = 1'b1;
        change_value_d = change_value;
        if (change_ready) begin
          remaining_d = rem_after;
          if (rem_after == '0) begin
            state_d        = S_IDLE;
            change_valid_d = 1'b0;
            change_value_d = '0;
          end else begin
            change_value_d = chunk(rem_after);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      credit       <= '0;
      remaining    <= '0;
      busy         <= 1'b0;
      vend_valid   <= 1'b0;
      vend_idx     <= '0;
      vend_count   <= '0;
      change_valid <= 1'b0;
      change_value <= '0;
      short_pulse  <= 1'b0;
      coin_reject  <= 1'b0;
    end else begin
      state        <= state_d;
      credit       <= credit_d;
      remaining    <= remaining_d;
      busy         <= busy_d;
      vend_valid   <= vend_valid_d;
      vend_idx     <= vend_idx_d;
      vend_count   <= vend_count_d;
      change_valid <= change_valid_d;
      change_value <= change_value_d;
      short_pulse  <= short_d;
      coin_reject  <= reject_d;
    end
  end

endmodule

// File: tb/tb_vend_txn.sv
module tb_vend_txn;
  localparam int DW       = 8;
  localparam int NPROD    = 4;
  localparam int COIN_MAX = 50;
  localparam int IW       = $clog2(NPROD);
  localparam int MAXV     = (1 << DW) - 1;
`ifdef VEND_CANCEL_EN
  localparam bit CANCEL_ON = 1'b1;
`else
  localparam bit CANCEL_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                rst_n;
  logic                coin_valid;
  logic [DW-1:0]       coin_value;
  logic                sel_valid;
  logic [IW-1:0]       sel_idx;
  logic [DW-1:0]       sel_count;
  logic [NPROD*DW-1:0] price_table;
  logic                cancel;
  logic                change_ready;
  logic [DW-1:0]       credit;
  logic                busy;
  logic                vend_valid;
  logic [IW-1:0]       vend_idx;
  logic [DW-1:0]       vend_count;
  logic                change_valid;
  logic [DW-1:0]       change_value;
  logic                short_pulse;
  logic                coin_reject;

  always #5 clk = ~clk;

  vend_txn #(.DW(DW), .NPROD(NPROD), .COIN_MAX(COIN_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .sel_count(sel_count),
    .price_table(price_table),
`ifdef VEND_CANCEL_EN
    .cancel(cancel),
`endif
    .change_ready(change_ready),
    .credit(credit), .busy(busy),
    .vend_valid(vend_valid), .vend_idx(vend_idx), .vend_count(vend_count),
    .change_valid(change_valid), .change_value(change_value),
    .short_pulse(short_pulse), .coin_reject(coin_reject)
  );

  // Unit prices per channel: 0:10, 1:15, 2:40, 3:5
  int prices[NPROD] = '{10, 15, 40, 5};

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction-level view: credit and remaining change as integers, plus
  // flags saying whether this cycle is a dispense pulse or a change offer.
  int m_credit, m_rem;
  bit m_vend, m_chg, m_short, m_reject;
  logic [IW+DW-1:0] exp_q[$];

  function automatic int min_chunk(input int r);
    return (r > COIN_MAX) ? COIN_MAX : r;
  endfunction

  task automatic model_reset();
    m_credit = 0; m_rem = 0;
    m_vend = 0; m_chg = 0; m_short = 0; m_reject = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int eff, cost, sidx, scnt;
    m_short  = 0;
    m_reject = 0;
    if (m_vend) begin
      m_reject = coin_valid;
      m_vend   = 0;
      m_chg    = (m_rem > 0);
    end else if (m_chg) begin
      m_reject = coin_valid;
      if (change_ready) begin
        m_rem = m_rem - min_chunk(m_rem);
        m_chg = (m_rem > 0);
      end
    end else begin
      eff = m_credit + (coin_valid ? int'(coin_value) : 0);
      if (eff > MAXV) eff = MAXV;
      sidx = int'(sel_idx);
      scnt = int'(sel_count);
      if (CANCEL_ON && cancel) begin
        m_reject = coin_valid;
        if (m_credit > 0) begin
          m_rem    = m_credit;
          m_credit = 0;
          m_chg    = 1;
        end
      end else if (sel_valid) begin
        cost = (sidx < NPROD) ? prices[sidx] * scnt : 0;
        if (sidx < NPROD && scnt > 0 && eff >= cost) begin
          m_vend   = 1;
          m_rem    = eff - cost;
          m_credit = 0;
          exp_q.push_back({sel_idx, sel_count});
        end else begin
          m_short  = 1;
          m_credit = eff;
        end
      end else begin
        m_credit = eff;
      end
    end
  endtask

  task automatic compare();
    logic [IW+DW-1:0] e;
    check("credit", int'(credit), m_credit);
    check("busy", int'(busy), int'(m_vend || m_chg));
    check("vend_valid", int'(vend_valid), int'(m_vend));
    check("change_valid", int'(change_valid), int'(m_chg));
    check("short_pulse", int'(short_pulse), int'(m_short));
    check("coin_reject", int'(coin_reject), int'(m_reject));
    if (m_chg) check("change_value", int'(change_value), min_chunk(m_rem));
    if (vend_valid) begin
      check("vend_q_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("vend_idx", int'(vend_idx), int'(e[IW+DW-1:DW]));
        check("vend_count", int'(vend_count), int'(e[DW-1:0]));
      end
    end
  endtask

  initial model_reset();

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step();
    #1;
    compare();
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit cv, input int cval, input bit sv, input int sidx,
                       input int scnt, input bit rdy, input bit can);
    coin_valid   = cv;
    coin_value   = cval[DW-1:0];
    sel_valid    = sv;
    sel_idx      = sidx[IW-1:0];
    sel_count    = scnt[DW-1:0];
    change_ready = rdy;
    cancel       = can;
    @(negedge clk);
  endtask

  task automatic coin(input int v);
    drive(1, v, 0, 0, 0, 1, 0);
  endtask

  task automatic sel(input int i, input int c);
    drive(0, 0, 1, i, c, 1, 0);
  endtask

  task automatic idle(input bit rdy);
    drive(0, 0, 0, 0, 0, rdy, 0);
  endtask

  // ---------------- stimulus ----------------
  int coin_set[6] = '{5, 10, 20, 25, 50, 100};
  int sum, chunks;

  initial begin
    rst_n = 1'b0;
    coin_valid = 0; coin_value = '0; sel_valid = 0; sel_idx = '0;
    sel_count = '0; change_ready = 0; cancel = 0;
    price_table = {8'd5, 8'd40, 8'd15, 8'd10};
    @(negedge clk);
    @(negedge clk);
    check("rst_credit", int'(credit), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_change_valid", int'(change_valid), 0);
    check("rst_vend_valid", int'(vend_valid), 0);
    rst_n = 1'b1;

    // Coins 20,20,10 then buy channel 1 (15) x2: vend next cycle, change 20.
    coin(20); coin(20); coin(10);
    check("d1_credit", int'(credit), 50);
    sel(1, 2);
    check("d1_vend_valid", int'(vend_valid), 1);
    check("d1_vend_idx", int'(vend_idx), 1);
    check("d1_vend_count", int'(vend_count), 2);
    check("d1_credit_after", int'(credit), 0);
    idle(1);
    check("d1_vend_pulse_end", int'(vend_valid), 0);
    check("d1_change_valid", int'(change_valid), 1);
    check("d1_change_value", int'(change_value), 20);
    idle(1);
    check("d1_idle_busy", int'(busy), 0);
    check("d1_idle_change", int'(change_valid), 0);

    // Credit 30, channel 1 x3 costs 45: refused, credit kept.
    coin(30);
    sel(1, 3);
    check("d2_short", int'(short_pulse), 1);
    check("d2_credit", int'(credit), 30);
    check("d2_busy", int'(busy), 0);
    idle(1);
    check("d2_short_end", int'(short_pulse), 0);
    sel(3, 6);
    check("d2_exact_vend", int'(vend_valid), 1);
    idle(1);
    check("d2_no_change", int'(change_valid), 0);
    check("d2_idle", int'(busy), 0);

    // Saturation at 255, then buy channel 3 (5): 250 paid as five 50s,
    // with a stalled dispenser and a coin during payout.
    coin(200); coin(55); coin(10);
    check("d3_sat", int'(credit), 255);
    sel(3, 1);
    idle(0);
    check("d3_chg_first", int'(change_value), 50);
    for (int i = 0; i < 5; i++) begin
      drive(i == 2, 25, 0, 0, 0, 0, 0);
      check("d4_hold_valid", int'(change_valid), 1);
      check("d4_hold_value", int'(change_value), 50);
      if (i == 2) begin
        check("d4_coin_reject", int'(coin_reject), 1);
        check("d4_credit", int'(credit), 0);
      end
    end
    sum = 0; chunks = 0;
    for (int i = 0; i < 20 && change_valid; i++) begin
      sum += int'(change_value);
      chunks++;
      idle(1);
    end
    check("d3_sum", sum, 250);
    check("d3_chunks", chunks, 5);
    check("d3_idle", int'(busy), 0);

    // Zero quantity is refused; same-cycle coin counts toward the purchase.
    sel(0, 0);
    check("d5_zero_cnt_short", int'(short_pulse), 1);
    check("d5_zero_cnt_credit", int'(credit), 0);
    drive(1, 20, 1, 0, 2, 1, 0);
    check("d5_coin_sel_vend", int'(vend_valid), 1);
    check("d5_coin_sel_count", int'(vend_count), 2);
    idle(1);
    check("d5_no_change", int'(change_valid), 0);

`ifdef VEND_CANCEL_EN
    // Cancel with 70 credit: refund 50 then 20.
    coin(70);
    drive(0, 0, 1, 0, 1, 1, 1);
    check("c1_change_valid", int'(change_valid), 1);
    check("c1_change_value", int'(change_value), 50);
    check("c1_credit", int'(credit), 0);
    check("c1_no_vend", int'(vend_valid), 0);
    idle(1);
    check("c1_change_value2", int'(change_value), 20);
    idle(1);
    check("c1_done", int'(change_valid), 0);
    coin(70);
    drive(1, 10, 0, 0, 0, 0, 1);
    check("c2_reject", int'(coin_reject), 1);
    check("c2_change_value", int'(change_value), 50);
`else
    // Reach CHANGE through a purchase: 100 credit, channel 0 -> 90 owed.
    coin(100);
    sel(0, 1);
    idle(0);
    check("r1_in_change", int'(change_valid), 1);
`endif
    // Reset in the middle of a payout drops everything immediately.
    idle(0);
    #2 rst_n = 1'b0;
    #1;
    check("r1_async_change_valid", int'(change_valid), 0);
    check("r1_async_change_value", int'(change_value), 0);
    check("r1_async_busy", int'(busy), 0);
    check("r1_async_credit", int'(credit), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    check("r1_discarded", int'(change_valid), 0);
    check("r1_idle", int'(busy), 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) < 3,
            ($urandom_range(0, 7) == 0) ? $urandom_range(0, MAXV) : coin_set[$urandom_range(0, 5)],
            $urandom_range(0, 9) < 2,
            $urandom_range(0, NPROD - 1),
            $urandom_range(0, 4),
            $urandom_range(0, 1),
            CANCEL_ON && ($urandom_range(0, 19) == 0));
    end

    for (int n = 0; n < 40; n++) idle(1);
    check("final_vend_q_empty", exp_q.size(), 0);
    check("final_idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_txn.md
VEND_TXN -- requirements
Module: vend_txn

Interface
REQ-001 SHALL have parameter DW, default 8, meaning the width of money, price and count datapaths.
REQ-002 SHALL have parameter NPROD, default 4, meaning the number of product channels (>=2); IW = $clog2(NPROD).
REQ-003 SHALL have parameter COIN_MAX, default 50, meaning the largest change amount dispensed per handshake (1..2^DW-1).
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-005 SHALL provide ports, each given as name direction width meaning:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- coin_valid  in  1  coin inserted this cycle
- coin_value  in  DW  coin amount
- sel_valid  in  1  purchase request
- sel_idx  in  IW  product channel
- sel_count  in  DW  quantity requested
- price_table  in  NPROD*DW  unit price per channel, channel i at bits [i*DW +: DW]
- cancel  in  1  refund request (present only with VEND_CANCEL_EN)
- change_ready  in  1  change dispenser accepts
- credit  out  DW  current credit
- busy  out  1  state is VEND or CHANGE
- vend_valid  out  1  one-cycle dispense pulse
- vend_idx  out  IW  channel dispensed
- vend_count  out  DW  quantity dispensed
- change_valid  out  1  change chunk offered
- change_value  out  DW  chunk amount
- short_pulse  out  1  one-cycle pulse: insufficient credit
- coin_reject  out  1  one-cycle pulse: coin refused

Function
REQ-006 SHALL implement FSM states IDLE (credit=0), COLLECT (credit>0), VEND and CHANGE; all outputs SHALL be registered.
REQ-007 SHALL, in IDLE/COLLECT, add coin_value to credit on coin_valid, saturating at 2^DW-1; any nonzero accepted coin SHALL move IDLE to COLLECT.
REQ-008 SHALL, on coin_valid while busy, leave credit unchanged and assert coin_reject the next cycle.
REQ-009 SHALL, on sel_valid in IDLE/COLLECT, form eff = sat(credit + coin_valid?coin_value:0) and cost = price[sel_idx]*sel_count at full 2*DW width, with no truncation in the comparison.
REQ-010 SHALL, when eff >= cost and sel_count != 0, enter VEND; in VEND it SHALL pulse vend_valid with the latched vend_idx and vend_count for exactly one cycle and SHALL set remaining = eff - cost.
REQ-011 SHALL, when eff < cost or sel_count == 0, pulse short_pulse the next cycle, keep credit = eff, and stay in or enter COLLECT (or IDLE if eff==0).
REQ-012 SHALL go from VEND to CHANGE if remaining != 0, otherwise to IDLE; credit SHALL be 0 after VEND.
REQ-013 SHALL, in CHANGE, hold change_valid=1 with change_value = min(remaining, COIN_MAX) stable until change_ready; on each handshake remaining SHALL decrement by change_value, and it SHALL go to IDLE in the cycle after the final chunk.
REQ-014 SHALL ignore sel_valid while busy, with no pulse generated.
REQ-015 SHALL give sel_valid and coin_valid in the same cycle the behaviour of REQ-009 (coin counted first); latency from sel to vend_valid SHALL be 1 cycle.
REQ-016 SHALL treat sel_idx >= NPROD as insufficient (short_pulse).

Reset
REQ-017 SHALL, on rst_n low, immediately force state IDLE with credit, remaining, vend_valid, vend_idx, vend_count, change_valid, change_value, short_pulse, coin_reject and busy all 0.
REQ-018 SHALL, on reset mid-CHANGE, discard the undispensed remainder, and SHALL drop change_valid asynchronously.

Configuration
REQ-019 SHALL support macro VEND_CANCEL_EN: when defined, cancel in COLLECT SHALL move credit into remaining and enter CHANGE (or stay in IDLE if credit is 0), cancel SHALL take priority over sel_valid and coin_valid, and a coin arriving in the same cycle SHALL be rejected.
REQ-020 SHALL, when VEND_CANCEL_EN is undefined, omit the cancel port and all refund logic.

Verification
REQ-021 SHALL cover: coins 20,20,10, then sel idx1 (price 15) count 2 -> vend_valid idx1 count2 one cycle later, then change 20 in one chunk, then IDLE.
REQ-022 SHALL cover: credit 30, sel price 15 count 3 -> short_pulse, credit stays 30, state COLLECT.
REQ-023 SHALL cover: credit 255 plus coin 10 -> credit 255 saturated; sel price 5 count 1 -> change chunks 50,50,50,50,50,0 never emitted, final chunk 0 excluded, i.e. chunks 50x5 then 0 remaining -> IDLE (250 total).
REQ-024 SHALL cover: change_ready held low 5 cycles -> change_value stable; coin during CHANGE -> coin_reject, credit unchanged.
REQ-025 SHALL cover: VEND_CANCEL_EN defined, credit 70, cancel -> change 50 then 20; assert rst_n low mid-CHANGE -> all outputs 0 at once.
